// File: rtl/v_lane_wb.sv
// v_lane_wb: writeback collector between the vector ALU/MUL lanes and the VRF.
// Two capture slots hold one result each and drain one chunk per accepted beat.
module v_lane_wb #(
  parameter int DATA_W  = 128,
  parameter int N_CHUNK = 4,
  parameter int VREG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_valu,
  input  logic              done_vmul,
  input  logic [DATA_W-1:0] result_valu_1,
  input  logic [DATA_W-1:0] result_valu_2,
  input  logic [DATA_W-1:0] result_valu_3,
  input  logic [DATA_W-1:0] result_valu_4,
  input  logic [DATA_W-1:0] result_vmul_1,
  input  logic [DATA_W-1:0] result_vmul_2,
  input  logic [DATA_W-1:0] result_vmul_3,
  input  logic [DATA_W-1:0] result_vmul_4,
  input  logic [VREG_W-1:0] vd_alu,
  input  logic [VREG_W-1:0] vd_mul,
  input  logic [2:0]        lmul,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [VREG_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_done_alu,
  output logic              wb_done_mul,
  output logic              busy,
  output logic              err
);
  localparam int IDX_W = $clog2(N_CHUNK);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WB_ALU = 2'd1, ST_WB_MUL = 2'd2} state_e;

  state_e              state_q, state_d;
  logic                done_valu_q, done_vmul_q;
  logic                alu_pend_q, alu_pend_d, mul_pend_q, mul_pend_d;
  logic [DATA_W-1:0]   alu_chunk_q [N_CHUNK];
  logic [DATA_W-1:0]   alu_chunk_d [N_CHUNK];
  logic [DATA_W-1:0]   mul_chunk_q [N_CHUNK];
  logic [DATA_W-1:0]   mul_chunk_d [N_CHUNK];
  logic [VREG_W-1:0]   alu_vd_q, alu_vd_d, mul_vd_q, mul_vd_d;
  logic [IDX_W-1:0]    alu_last_q, alu_last_d, mul_last_q, mul_last_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                done_alu_q, done_alu_d, done_mul_q, done_mul_d;
  logic                err_q, err_d;

  logic                alu_rise_s, mul_rise_s, beat_s, alu_fin_s, mul_fin_s;
  logic                alu_cap_s, mul_cap_s, lmul_rsvd_s;
  logic [IDX_W-1:0]    lmul_last_s;
  logic [VREG_W-1:0]   wb_addr_s;
  logic [DATA_W-1:0]   wb_data_s;

  assign alu_rise_s = done_valu & ~done_valu_q;
  assign mul_rise_s = done_vmul & ~done_vmul_q;
  assign wb_valid   = (state_q != ST_IDLE);
  assign beat_s     = wb_valid & wb_ready;
  assign alu_fin_s  = beat_s & (state_q == ST_WB_ALU) & (idx_q == alu_last_q);
  assign mul_fin_s  = beat_s & (state_q == ST_WB_MUL) & (idx_q == mul_last_q);
  // A slot reloads when empty or when its final beat leaves in the same cycle.
  assign alu_cap_s  = alu_rise_s & (~alu_pend_q | alu_fin_s);
  assign mul_cap_s  = mul_rise_s & (~mul_pend_q | mul_fin_s);

  // Decode lmul into the index of the last chunk to write.
  always_comb begin
    lmul_last_s = {IDX_W{1'b0}};
    lmul_rsvd_s = 1'b0;
    case (lmul)
      3'd0:    lmul_last_s = IDX_W'(0);
      3'd1:    lmul_last_s = IDX_W'(1);
      3'd2:    lmul_last_s = IDX_W'(3);
      default: begin
        lmul_last_s = IDX_W'(0);
        lmul_rsvd_s = 1'b1;
      end
    endcase
  end

  // Capture slots, sticky error and done pulses.
  always_comb begin
    alu_chunk_d = alu_chunk_q;
    mul_chunk_d = mul_chunk_q;
    alu_vd_d    = alu_vd_q;
    mul_vd_d    = mul_vd_q;
    alu_last_d  = alu_last_q;
    mul_last_d  = mul_last_q;
    alu_pend_d  = alu_pend_q;
    mul_pend_d  = mul_pend_q;
    if (alu_cap_s) begin
      alu_chunk_d[0] = result_valu_1;
      alu_chunk_d[1] = result_valu_2;
      alu_chunk_d[2] = result_valu_3;
      alu_chunk_d[3] = result_valu_4;
      alu_vd_d       = vd_alu;
      alu_last_d     = lmul_last_s;
      alu_pend_d     = 1'b1;
    end else if (alu_fin_s) begin
      alu_pend_d = 1'b0;
    end else begin
      alu_pend_d = alu_pend_q;
    end
    if (mul_cap_s) begin
      mul_chunk_d[0] = result_vmul_1;
      mul_chunk_d[1] = result_vmul_2;
      mul_chunk_d[2] = result_vmul_3;
      mul_chunk_d[3] = result_vmul_4;
      mul_vd_d       = vd_mul;
      mul_last_d     = lmul_last_s;
      mul_pend_d     = 1'b1;
    end else if (mul_fin_s) begin
      mul_pend_d = 1'b0;
    end else begin
      mul_pend_d = mul_pend_q;
    end
    err_d = err_q | (alu_rise_s & ~alu_cap_s) | (mul_rise_s & ~mul_cap_s) |
            ((alu_rise_s | mul_rise_s) & lmul_rsvd_s);
    done_alu_d = alu_fin_s;
    done_mul_d = mul_fin_s;
  end

  // Drain FSM and chunk index; the last beat hands over to the other slot without a bubble.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (alu_pend_q) begin
          state_d = ST_WB_ALU;
        end else if (mul_pend_q) begin
          state_d = ST_WB_MUL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB_ALU: begin
        if (alu_fin_s) begin
          state_d = mul_pend_q ? ST_WB_MUL : ST_IDLE;
        end else begin
          state_d = ST_WB_ALU;
        end
      end
      ST_WB_MUL: begin
        if (mul_fin_s) begin
          state_d = alu_pend_q ? ST_WB_ALU : ST_IDLE;
        end else begin
          state_d = ST_WB_MUL;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (alu_fin_s | mul_fin_s) begin
      idx_d = {IDX_W{1'b0}};
    end else if (beat_s) begin
      idx_d = idx_q + IDX_W'(1);
    end else begin
      idx_d = idx_q;
    end
  end

  // Beat address/data from the slot being drained; zero when idle.
  always_comb begin
    wb_addr_s = {VREG_W{1'b0}};
    wb_data_s = {DATA_W{1'b0}};
    case (state_q)
      ST_WB_ALU: begin
        wb_addr_s = alu_vd_q + VREG_W'(idx_q);
        wb_data_s = alu_chunk_q[idx_q];
      end
      ST_WB_MUL: begin
        wb_addr_s = mul_vd_q + VREG_W'(idx_q);
        wb_data_s = mul_chunk_q[idx_q];
      end
      default: begin
        wb_addr_s = {VREG_W{1'b0}};
        wb_data_s = {DATA_W{1'b0}};
      end
    endcase
  end

  assign wb_addr     = wb_addr_s;
  assign wb_data     = wb_data_s;
  assign wb_done_alu = done_alu_q;
  assign wb_done_mul = done_mul_q;
  assign err         = err_q;
  assign busy        = alu_pend_q | mul_pend_q | (state_q != ST_IDLE);

  // State register; edge detectors reset to 1 so a level held through reset is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      done_valu_q <= 1'b1;
      done_vmul_q <= 1'b1;
      alu_pend_q  <= 1'b0;
      mul_pend_q  <= 1'b0;
      for (int k = 0; k < N_CHUNK; k++) begin
        alu_chunk_q[k] <= {DATA_W{1'b0}};
        mul_chunk_q[k] <= {DATA_W{1'b0}};
      end
      alu_vd_q    <= {VREG_W{1'b0}};
      mul_vd_q    <= {VREG_W{1'b0}};
      alu_last_q  <= {IDX_W{1'b0}};
      mul_last_q  <= {IDX_W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      done_alu_q  <= 1'b0;
      done_mul_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      done_valu_q <= done_valu;
      done_vmul_q <= done_vmul;
      alu_pend_q  <= alu_pend_d;
      mul_pend_q  <= mul_pend_d;
      alu_chunk_q <= alu_chunk_d;
      mul_chunk_q <= mul_chunk_d;
      alu_vd_q    <= alu_vd_d;
      mul_vd_q    <= mul_vd_d;
      alu_last_q  <= alu_last_d;
      mul_last_q  <= mul_last_d;
      idx_q       <= idx_d;
      done_alu_q  <= done_alu_d;
      done_mul_q  <= done_mul_d;
      err_q       <= err_d;
    end
  end
endmodule
